// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART byte framer: FSM state codes,
// error codes, default sync bytes and the length-legality helper.
package uart_frame_pkg;

    localparam logic [2:0] ST_HUNT0   = 3'd0;
    localparam logic [2:0] ST_HUNT1   = 3'd1;
    localparam logic [2:0] ST_LEN     = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_CSUM    = 3'd4;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0]  SYNC0_DEF   = 8'h55;
    localparam logic [7:0]  SYNC1_DEF   = 8'hAA;
    localparam logic [7:0]  MAX_LEN_DEF = 8'd64;
    localparam logic [15:0] TIMEOUT_DEF = 16'd5000;

    function automatic logic len_bad(
        input logic [7:0] len,
        input logic [7:0] max_len
    );
        return (len == 8'd0) || (len > max_len);
    endfunction

endpackage

// File: rtl/uart_rx_idle_timer.sv
// Idle-gap counter: counts enabled cycles without a clear and pulses
// tc on the cycle the gap reaches TERMINAL, then restarts from zero.
module uart_rx_idle_timer #(
    parameter logic [15:0] TERMINAL = 16'd5000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    logic [15:0] count;

    // A clear on the terminal cycle suppresses the pulse.
    assign tc = en && !clr && (count == TERMINAL - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 16'd0;
        end else if (!en || clr || tc) begin
            count <= 16'd0;
        end else begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// Framer behind a UART receiver: sync hunt, length, payload, checksum.
// Define UART_RX_FRAME_TIMEOUT_EN to abort frames after an idle gap.
module uart_rx_frame
    import uart_frame_pkg::*;
#(
    parameter logic [7:0]  SYNC0       = SYNC0_DEF,
    parameter logic [7:0]  SYNC1       = SYNC1_DEF,
    parameter logic [7:0]  MAX_LEN     = MAX_LEN_DEF,
    parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_RX_en,
    input  logic [7:0] i_RX_word,
    output logic       o_data_valid,
    output logic [7:0] o_data,
    output logic       o_data_last,
    output logic       o_frame_ok,
    output logic       o_frame_err,
    output logic [1:0] o_err_code
);

    logic [2:0] state;
    logic [7:0] cnt;
    logic [7:0] sum;
    logic       timeout;

`ifdef UART_RX_FRAME_TIMEOUT_EN
    uart_rx_idle_timer #(
        .TERMINAL(TIMEOUT_CYC)
    ) u_idle (
        .clk(clk),
        .rst(rst),
        .en (state != ST_HUNT0),
        .clr(i_RX_en),
        .tc (timeout)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_HUNT0;
            cnt          <= 8'd0;
            sum          <= 8'd0;
            o_data_valid <= 1'b0;
            o_data       <= 8'd0;
            o_data_last  <= 1'b0;
            o_frame_ok   <= 1'b0;
            o_frame_err  <= 1'b0;
            o_err_code   <= ERR_NONE;
        end else begin
            o_data_valid <= 1'b0;
            o_data_last  <= 1'b0;
            o_frame_ok   <= 1'b0;
            o_frame_err  <= 1'b0;
            o_err_code   <= ERR_NONE;
            // A byte always wins over a coincident idle expiry.
            if (i_RX_en) begin
                unique case (state)
                    ST_HUNT0: begin
                        if (i_RX_word == SYNC0)
                            state <= ST_HUNT1;
                    end
                    ST_HUNT1: begin
                        if (i_RX_word == SYNC1)
                            state <= ST_LEN;
                        else if (i_RX_word != SYNC0)
                            state <= ST_HUNT0;
                    end
                    ST_LEN: begin
                        if (len_bad(i_RX_word, MAX_LEN)) begin
                            o_frame_err <= 1'b1;
                            o_err_code  <= ERR_LEN;
                            state       <= ST_HUNT0;
                        end else begin
                            cnt   <= i_RX_word;
                            sum   <= i_RX_word;
                            state <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        o_data_valid <= 1'b1;
                        o_data       <= i_RX_word;
                        sum          <= sum + i_RX_word;
                        cnt          <= cnt - 8'd1;
                        if (cnt == 8'd1) begin
                            o_data_last <= 1'b1;
                            state       <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        if (i_RX_word == sum) begin
                            o_frame_ok <= 1'b1;
                        end else begin
                            o_frame_err <= 1'b1;
                            o_err_code  <= ERR_CSUM;
                        end
                        state <= ST_HUNT0;
                    end
                    default: state <= ST_HUNT0;
                endcase
            end else if (timeout) begin
                o_frame_err <= 1'b1;
                o_err_code  <= ERR_TIMEOUT;
                state       <= ST_HUNT0;
            end
        end
    end

endmodule
